// File: rtl/mips_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_lsu_pkg
// Description : Shared types and constants for the MIPS load/store unit:
//               access-size enum, FSM state enum, store lane-mask constants
//               and the natural-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Lane i is data bits [8i+7:8i] and corresponds to byte offset i.
  localparam logic [3:0] c_MASK_BYTE    = 4'b0001;
  localparam logic [3:0] c_MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] c_MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] c_MASK_WORD    = 4'b1111;

  // Clears the low address bits that a given access size cannot use.
  // Size code 3 is not a legal encoding and is handled as a word.
  function automatic logic [1:0] force_align(input logic [1:0] size,
                                             input logic [1:0] lo);
    if (size == BYTE)      return lo;
    else if (size == HALF) return {lo[1], 1'b0};
    else                   return 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : mips_lsu_align
// Description : Combinational lane steering for the load/store unit.
//               Store side: byte-enable mask and replicated write data.
//               Load side : addressed byte/half extraction with zero or sign
//               extension.
// Ports       : size_i    - access size (BYTE/HALF/WORD)
//               addr_lo_i - byte offset within the word
//               signed_i  - sign-extend loaded byte/half
//               wdata_i   - raw store data (rt)
//               rdata_i   - raw word returned by memory
//               be_o      - store lane mask
//               wdata_o   - replicated store data
//               rdata_o   - aligned, extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: w_byte = rdata_i[7:0];
      2'd1: w_byte = rdata_i[15:8];
      2'd2: w_byte = rdata_i[23:16];
      2'd3: w_byte = rdata_i[31:24];
      default: w_byte = rdata_i[7:0];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o    = c_MASK_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    if (size_i == BYTE) begin
      be_o    = c_MASK_BYTE << addr_lo_i;
      wdata_o = {4{wdata_i[7:0]}};
      rdata_o = {{24{signed_i & w_byte[7]}}, w_byte};
    end else if (size_i == HALF) begin
      be_o    = addr_lo_i[1] ? c_MASK_HALF_HI : c_MASK_HALF_LO;
      wdata_o = {2{wdata_i[15:0]}};
      rdata_o = {{16{signed_i & w_half[15]}}, w_half};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mips_lsu
// Description : MIPS data-side load/store unit. Accepts one request from the
//               core, runs a single memory transaction (IDLE -> ACCESS ->
//               DONE), steers lanes and extends load data, and reports bus
//               errors (error response or timeout).
// Config      : MIPS_LSU_ALIGN_CHECK_EN - when defined, misaligned requests
//               raise excpt_adel/excpt_ades instead of being force-aligned.
// Ports       : clk, rst                    - clock, async active-high reset
//               req_*                       - core request
//               stall, resp_valid, resp_rdata - core response
//               excpt_adel/ades/dbe         - exception pulses
//               mem_req/addr/data_in/write_en - memory request
//               mem_ack/data_out/excpt      - memory response
// Revision    : 1.0 - initial release
// ============================================================================
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              excpt_adel,
  output logic              excpt_ades,
  output logic              excpt_dbe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_write_en,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data_out,
  input  logic              mem_excpt
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               dbe_q, dbe_d;
  logic               we_q;
  logic [1:0]         size_q;
  logic               signed_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;

  logic               w_accept;
  logic               w_adel;
  logic               w_ades;
  logic [31:0]        w_addr_eff;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_rep;
  logic [31:0]        w_load_ext;

  // Request qualification. Gated by rst so nothing is accepted or flagged
  // while reset is held.
`ifdef MIPS_LSU_ALIGN_CHECK_EN
  logic w_misaligned;
  always_comb begin
    if (req_size == BYTE)      w_misaligned = 1'b0;
    else if (req_size == HALF) w_misaligned = req_addr[0];
    else                       w_misaligned = (req_addr[1:0] != 2'b00);
  end
  assign w_addr_eff = req_addr;
  assign w_accept   = ~rst & (state_q == ST_IDLE) & req_valid & ~w_misaligned;
  assign w_adel     = ~rst & (state_q == ST_IDLE) & req_valid & w_misaligned & ~req_we;
  assign w_ades     = ~rst & (state_q == ST_IDLE) & req_valid & w_misaligned & req_we;
`else
  assign w_addr_eff = {req_addr[31:2], force_align(req_size, req_addr[1:0])};
  assign w_accept   = ~rst & (state_q == ST_IDLE) & req_valid;
  assign w_adel     = 1'b0;
  assign w_ades     = 1'b0;
`endif

  // Steering works from the registered request so memory-side signals stay
  // stable for the whole ACCESS phase.
  mips_lsu_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .signed_i  (signed_q),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_data_out),
    .be_o      (w_be),
    .wdata_o   (w_wdata_rep),
    .rdata_o   (w_load_ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dbe_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (w_accept) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q != c_CNT_SAT) cnt_d = cnt_q + 1'b1;
        // An error response wins over a simultaneous ack.
        if (mem_excpt) begin
          state_d = ST_IDLE;
          dbe_d   = 1'b1;
        end else if (mem_ack) begin
          state_d = ST_DONE;
        end else if (cnt_q >= c_CNT_LAST) begin
          state_d = ST_IDLE;
          dbe_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dbe_q    <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dbe_q   <= dbe_d;
      if (w_accept) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= w_addr_eff;
        wdata_q  <= req_wdata;
      end
      if ((state_q == ST_ACCESS) && mem_ack && !mem_excpt && !we_q) begin
        rdata_q <= w_load_ext;
      end
    end
  end

  assign stall        = w_accept | (state_q == ST_ACCESS);
  assign resp_valid   = (state_q == ST_DONE);
  assign resp_rdata   = rdata_q;
  assign excpt_adel   = w_adel;
  assign excpt_ades   = w_ades;
  assign excpt_dbe    = dbe_q;
  assign mem_req      = (state_q == ST_ACCESS);
  assign mem_addr     = addr_q[ADDR_W+1:2];
  assign mem_data_in  = w_wdata_rep;
  assign mem_write_en = ((state_q == ST_ACCESS) && we_q) ? w_be : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_mips_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_lsu
// Description : Directed self-checking bench for mips_lsu. Each scenario task
//               drives its own stimulus and compares against hand-computed
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_lsu;

  localparam logic [1:0] c_SZ_B = 2'd0;
  localparam logic [1:0] c_SZ_H = 2'd1;
  localparam logic [1:0] c_SZ_W = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall, resp_valid, excpt_adel, excpt_ades, excpt_dbe, mem_req;
  logic [31:0] resp_rdata, mem_data_in;
  logic [29:0] mem_addr;
  logic [3:0]  mem_write_en;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data_out = '0;
  logic        mem_excpt = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mips_lsu #(.TIMEOUT_CYCLES(255), .ADDR_W(30)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .excpt_adel(excpt_adel), .excpt_ades(excpt_ades),
    .excpt_dbe(excpt_dbe), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_write_en(mem_write_en), .mem_ack(mem_ack),
    .mem_data_out(mem_data_out), .mem_excpt(mem_excpt)
  );

  // Stimulus/observation only: one complete access with ack in the cycle
  // after accept. Starts and ends on a falling edge with the unit idle.
  task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd,
                            output logic o_stall_acc, output logic o_mreq,
                            output logic [29:0] o_maddr, output logic [3:0] o_mwe,
                            output logic [31:0] o_mdin, output logic o_rv,
                            output logic o_stall_done, output logic [31:0] o_rdata);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    #1 o_stall_acc = stall;
    @(negedge clk);
    req_valid = 1'b0;
    o_mreq = mem_req; o_maddr = mem_addr; o_mwe = mem_write_en; o_mdin = mem_data_in;
    mem_ack = 1'b1; mem_data_out = rd;
    @(negedge clk);
    mem_ack = 1'b0;
    o_rv = resp_valid; o_stall_done = stall; o_rdata = resp_rdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_size = c_SZ_W; req_addr = 32'h1000_0000;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if ({excpt_adel, excpt_ades, excpt_dbe} !== 3'b000) begin n_fails++; $display("FAIL reset_excpt: got %b want 000", {excpt_adel, excpt_ades, excpt_dbe}); end
    n_checks++; if (mem_req !== 1'b0) begin n_fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (mem_write_en !== 4'b0000) begin n_fails++; $display("FAIL reset_mem_we: got %b want 0000", mem_write_en); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fails++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    n_checks++; if (mem_addr !== 30'h0) begin n_fails++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    logic sa, mr, rv, sd; logic [29:0] ma; logic [3:0] we; logic [31:0] di, rdv;
    run_access(1'b0, c_SZ_W, 1'b0, 32'h1000_0008, 32'h0, 32'hDEAD_BEEF, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if (sa !== 1'b1) begin n_fails++; $display("FAIL lw_stall_accept: got %b want 1", sa); end
    n_checks++; if (mr !== 1'b1) begin n_fails++; $display("FAIL lw_mem_req: got %b want 1", mr); end
    n_checks++; if (ma !== 30'h0400_0002) begin n_fails++; $display("FAIL lw_mem_addr: got %h want 04000002", ma); end
    n_checks++; if (we !== 4'b0000) begin n_fails++; $display("FAIL lw_mem_we: got %b want 0000", we); end
    n_checks++; if (rv !== 1'b1) begin n_fails++; $display("FAIL lw_resp_valid: got %b want 1", rv); end
    n_checks++; if (sd !== 1'b0) begin n_fails++; $display("FAIL lw_stall_done: got %b want 0", sd); end
    n_checks++; if (rdv !== 32'hDEAD_BEEF) begin n_fails++; $display("FAIL lw_rdata: got %h want deadbeef", rdv); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fails++; $display("FAIL lw_resp_pulse: got %b want 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin n_fails++; $display("FAIL lw_rdata_hold: got %h want deadbeef", resp_rdata); end
  endtask

  task automatic test_loads_sub_word();
    logic sa, mr, rv, sd; logic [29:0] ma; logic [3:0] we; logic [31:0] di, rdv;
    run_access(1'b0, c_SZ_B, 1'b1, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if (rdv !== 32'hFFFF_FF80) begin n_fails++; $display("FAIL lb_signed: got %h want ffffff80", rdv); end
    run_access(1'b0, c_SZ_B, 1'b0, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if (rdv !== 32'h0000_0080) begin n_fails++; $display("FAIL lbu: got %h want 00000080", rdv); end
    run_access(1'b0, c_SZ_B, 1'b1, 32'h1000_0001, 32'h0, 32'h1122_7F44, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if (rdv !== 32'h0000_007F) begin n_fails++; $display("FAIL lb_off1: got %h want 0000007f", rdv); end
    run_access(1'b0, c_SZ_H, 1'b1, 32'h1000_0002, 32'h0, 32'h8001_5555, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if (rdv !== 32'hFFFF_8001) begin n_fails++; $display("FAIL lh_signed: got %h want ffff8001", rdv); end
    run_access(1'b0, c_SZ_H, 1'b0, 32'h1000_0000, 32'h0, 32'h5555_9ABC, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if (rdv !== 32'h0000_9ABC) begin n_fails++; $display("FAIL lhu: got %h want 00009abc", rdv); end
  endtask

  task automatic test_stores();
    logic sa, mr, rv, sd; logic [29:0] ma; logic [3:0] we; logic [31:0] di, rdv;
    run_access(1'b1, c_SZ_H, 1'b0, 32'h1000_0002, 32'h0000_1234, 32'h0, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if (we !== 4'b1100) begin n_fails++; $display("FAIL sh_mask: got %b want 1100", we); end
    n_checks++; if (di !== 32'h1234_1234) begin n_fails++; $display("FAIL sh_data: got %h want 12341234", di); end
    n_checks++; if (rv !== 1'b1) begin n_fails++; $display("FAIL sh_resp_valid: got %b want 1", rv); end
    run_access(1'b1, c_SZ_B, 1'b0, 32'h2000_0011, 32'hFFFF_FFA5, 32'h0, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if (we !== 4'b0010) begin n_fails++; $display("FAIL sb_mask: got %b want 0010", we); end
    n_checks++; if (di !== 32'hA5A5_A5A5) begin n_fails++; $display("FAIL sb_data: got %h want a5a5a5a5", di); end
    n_checks++; if (ma !== 30'h0800_0004) begin n_fails++; $display("FAIL sb_addr: got %h want 08000004", ma); end
    run_access(1'b1, c_SZ_W, 1'b0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if (we !== 4'b1111) begin n_fails++; $display("FAIL sw_mask: got %b want 1111", we); end
    n_checks++; if (di !== 32'hCAFE_F00D) begin n_fails++; $display("FAIL sw_data: got %h want cafef00d", di); end
  endtask

  task automatic test_timeout();
    int cycles; logic seen_rv;
    req_valid = 1'b1; req_we = 1'b0; req_size = c_SZ_W; req_addr = 32'h1000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    cycles = 0; seen_rv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!mem_req) break;
      cycles++;
      if (resp_valid) seen_rv = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (cycles !== 255) begin n_fails++; $display("FAIL timeout_cycles: got %0d want 255", cycles); end
    n_checks++; if (excpt_dbe !== 1'b1) begin n_fails++; $display("FAIL timeout_dbe: got %b want 1", excpt_dbe); end
    n_checks++; if ({mem_req, stall} !== 2'b00) begin n_fails++; $display("FAIL timeout_req_stall: got %b want 00", {mem_req, stall}); end
    n_checks++; if (seen_rv !== 1'b0) begin n_fails++; $display("FAIL timeout_resp: got %b want 0", seen_rv); end
    @(negedge clk);
    n_checks++; if ({excpt_dbe, resp_valid} !== 2'b00) begin n_fails++; $display("FAIL timeout_pulse: got %b want 00", {excpt_dbe, resp_valid}); end
  endtask

  task automatic test_bus_error();
    req_valid = 1'b1; req_we = 1'b1; req_size = c_SZ_W; req_addr = 32'h1000_0080;
    @(negedge clk);
    req_valid = 1'b0; mem_ack = 1'b1; mem_excpt = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_excpt = 1'b0;
    n_checks++; if ({excpt_dbe, resp_valid, mem_req} !== 3'b100) begin n_fails++; $display("FAIL buserr_pulse: got %b want 100", {excpt_dbe, resp_valid, mem_req}); end
    @(negedge clk);
    n_checks++; if ({excpt_dbe, resp_valid} !== 2'b00) begin n_fails++; $display("FAIL buserr_after: got %b want 00", {excpt_dbe, resp_valid}); end
  endtask

  task automatic test_misalign();
    req_valid = 1'b1; req_we = 1'b0; req_size = c_SZ_W; req_addr = 32'h1000_0002;
    #1;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    n_checks++; if ({excpt_adel, excpt_ades, stall} !== 3'b100) begin n_fails++; $display("FAIL mis_lw: got %b want 100", {excpt_adel, excpt_ades, stall}); end
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fails++; $display("FAIL mis_lw_noreq: got %b want 0", mem_req); end
    req_we = 1'b1; req_size = c_SZ_H; req_addr = 32'h1000_0001;
    #1;
    n_checks++; if ({excpt_adel, excpt_ades, stall} !== 3'b010) begin n_fails++; $display("FAIL mis_sh: got %b want 010", {excpt_adel, excpt_ades, stall}); end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mem_req !== 1'b0) begin n_fails++; $display("FAIL mis_sh_noreq: got %b want 0", mem_req); end
`else
    n_checks++; if ({excpt_adel, excpt_ades, stall} !== 3'b001) begin n_fails++; $display("FAIL mis_lw_accept: got %b want 001", {excpt_adel, excpt_ades, stall}); end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mem_addr !== 30'h0400_0000) begin n_fails++; $display("FAIL mis_lw_addr: got %h want 04000000", mem_addr); end
    mem_ack = 1'b1; mem_data_out = 32'h0BAD_CAFE;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++; if (resp_rdata !== 32'h0BAD_CAFE) begin n_fails++; $display("FAIL mis_lw_rdata: got %h want 0badcafe", resp_rdata); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_during_access();
    logic sa, mr, rv, sd, bad; logic [29:0] ma; logic [3:0] we; logic [31:0] di, rdv;
    req_valid = 1'b1; req_we = 1'b1; req_size = c_SZ_W; req_addr = 32'h1000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mem_req !== 1'b1) begin n_fails++; $display("FAIL rsta_in_access: got %b want 1", mem_req); end
    mem_ack = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++; if ({stall, resp_valid, mem_req, mem_write_en} !== 7'b0) begin n_fails++; $display("FAIL rsta_outputs: got %b want 0", {stall, resp_valid, mem_req, mem_write_en}); end
    n_checks++; if ({mem_addr, resp_rdata} !== 62'b0) begin n_fails++; $display("FAIL rsta_addr_rdata: got %h want 0", {mem_addr, resp_rdata}); end
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || excpt_dbe || mem_req) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) begin n_fails++; $display("FAIL rsta_abandon: got %b want 0", bad); end
    run_access(1'b0, c_SZ_W, 1'b0, 32'h1000_0008, 32'h0, 32'h1357_9BDF, sa, mr, ma, we, di, rv, sd, rdv);
    n_checks++; if ({rv, rdv} !== {1'b1, 32'h1357_9BDF}) begin n_fails++; $display("FAIL rsta_next_lw: got %b/%h want 1/13579bdf", rv, rdv); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_we = 1'b0; req_size = c_SZ_W; req_addr = 32'h1000_0020;
    @(negedge clk);
    mem_ack = 1'b1; mem_data_out = 32'h0000_0001;
    // Request stays up through DONE; it must be ignored there.
    req_we = 1'b1; req_addr = 32'h1000_0024; req_wdata = 32'hA0A0_A0A0;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++; if ({resp_valid, stall} !== 2'b10) begin n_fails++; $display("FAIL b2b_done: got %b want 10", {resp_valid, stall}); end
    @(negedge clk);
    n_checks++; if ({mem_req, stall} !== 2'b01) begin n_fails++; $display("FAIL b2b_accept2: got %b want 01", {mem_req, stall}); end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if ({mem_req, mem_write_en, mem_addr} !== {1'b1, 4'b1111, 30'h0400_0009}) begin n_fails++; $display("FAIL b2b_store: got %b %b %h want 1 1111 04000009", mem_req, mem_write_en, mem_addr); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h0000_0001}) begin n_fails++; $display("FAIL b2b_resp2: got %b/%h want 1/00000001", resp_valid, resp_rdata); end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lw();
    test_loads_sub_word();
    test_stores();
    test_timeout();
    test_bus_error();
    test_misalign();
    test_reset_during_access();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_lsu.md
MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles before a bus error is declared.
REQ-002 SHALL have parameter ADDR_W, default 30: word-address width toward data memory.
REQ-003 SHALL have clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have req_valid, input, 1: core presents a load/store this cycle.
REQ-006 SHALL have req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have req_size, input, 2: access size, one of BYTE, HALF, WORD.
REQ-008 SHALL have req_signed, input, 1: sign-extend load data (LB/LH) when 1.
REQ-009 SHALL have req_addr, input, 32: byte address (base + se_mem_offset).
REQ-010 SHALL have req_wdata, input, 32: store data (rt value).
REQ-011 SHALL have stall, output, 1: core must hold PC and request.
REQ-012 SHALL have resp_valid, output, 1: one-cycle pulse, access complete.
REQ-013 SHALL have resp_rdata, output, 32: aligned, extended load result.
REQ-014 SHALL have excpt_adel, excpt_ades, excpt_dbe, each output, 1: one-cycle exception pulses.
REQ-015 SHALL have mem_req, output, 1; mem_addr, output, ADDR_W; mem_data_in, output, 32; mem_write_en, output, 4: memory-side request.
REQ-016 SHALL have mem_ack, input, 1; mem_data_out, input, 32; mem_excpt, input, 1: memory-side response.

Function
REQ-017 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-018 In IDLE, SHALL accept req_valid with a legal alignment, register all request fields, move to ACCESS, and assert stall combinationally in the accept cycle.
REQ-019 In ACCESS, SHALL hold mem_req=1 and keep mem_addr, mem_data_in, and mem_write_en stable until the access terminates.
REQ-020 In ACCESS, mem_ack SHALL capture mem_data_out and go to DONE; mem_excpt SHALL pulse excpt_dbe and return to IDLE; mem_excpt together with mem_ack SHALL be treated as mem_excpt.
REQ-021 SHALL count ACCESS cycles with a saturating counter cleared on entry; reaching TIMEOUT_CYCLES without an ack SHALL pulse excpt_dbe, drop mem_req, and return to IDLE.
REQ-022 In DONE, SHALL pulse resp_valid with stall=0, then return to IDLE; req_valid SHALL be ignored in DONE.
REQ-023 Minimum latency SHALL be: accept cycle N, mem_ack in N+1, resp_valid in N+2.
REQ-024 Lane i SHALL be bits 8i+7:8i and map to byte offset i.
REQ-025 Store lane masks SHALL be: BYTE = 1 shifted left by addr[1:0]; HALF = 0011 or 1100 by addr[1]; WORD = 1111.
REQ-026 mem_data_in SHALL replicate store data: {4{b}}, {2{h}}, or the word.
REQ-027 Loads SHALL drive mem_write_en=0.
REQ-028 resp_rdata SHALL select the addressed byte or half and zero- or sign-extend it per req_signed; resp_rdata SHALL hold its value until the next response.
REQ-029 mem_addr SHALL equal addr[31:2].

Reset
REQ-030 Asserting rst SHALL immediately force IDLE and clear the counter.
REQ-031 Under reset, stall, resp_valid, all excpt_*, mem_req, and mem_write_en SHALL be 0, and resp_rdata and mem_addr SHALL be 0.
REQ-032 Reset during ACCESS SHALL abandon the access with no response or exception.

Configuration
REQ-033 With MIPS_LSU_ALIGN_CHECK_EN defined, a misaligned request in IDLE (HALF with addr[0]=1, or WORD with addr[1:0]!=0) SHALL pulse excpt_adel (load) or excpt_ades (store) in the request cycle, issue no memory access, and keep stall low.
REQ-034 Without MIPS_LSU_ALIGN_CHECK_EN, the low address bits SHALL be forced to the natural alignment, excpt_adel and excpt_ades SHALL be tied to 0, and the access SHALL proceed.

Structure
REQ-035 Package mips_lsu_pkg SHALL hold the size enum (BYTE=0, HALF=1, WORD=2), the FSM state enum, and lane-mask constants.
REQ-036 Sub-module mips_lsu_align SHALL hold the combinational lane steering and extension for both store masks and load extraction.

Verification
REQ-037 LW at 0x10000008 with mem_ack the next cycle and mem_data_out=0xDEADBEEF -> mem_addr=0x04000002, resp_valid two cycles after accept, resp_rdata=0xDEADBEEF.
REQ-038 LB signed at offset 3 with mem_data_out=0x80FFFFFF -> resp_rdata=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-039 SH of 0x00001234 at offset 2 -> mem_write_en=1100, mem_data_in=0x12341234, resp_valid pulsed.
REQ-040 Load with mem_ack withheld for TIMEOUT_CYCLES (255) -> one excpt_dbe pulse, mem_req low, stall low, no resp_valid.
REQ-041 With the macro defined, LW at 0x10000002 -> excpt_adel in the same cycle and mem_req never asserts; without the macro -> access to 0x10000000.
REQ-042 rst asserted during ACCESS, then released -> IDLE, all outputs 0, and the next LW completes normally.
